// File: rtl/vga_timing_gen.sv
// VGA/LCD timing generator: sync/blank/coordinate generation from free-running
// line and frame counters, popping pixels from a show-ahead FIFO during the active area.
module vga_timing_gen #(
  parameter int HDISP  = 800,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VDISP  = 480,
  parameter int VFP    = 13,
  parameter int VPULSE = 3,
  parameter int VBP    = 29,
  parameter int RGB_W  = 24
) (
  input  logic             pixel_clk,
  input  logic             pixel_rst,
  input  logic             en,
  input  logic [RGB_W-1:0] fifo_rdata,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  output logic             VGA_HS,
  output logic             VGA_VS,
  output logic             VGA_BLANK,
  output logic [RGB_W-1:0] VGA_RGB,
  output logic [10:0]      pixel_x,
  output logic [10:0]      pixel_y,
  output logic             frame_start,
  output logic             underflow
);

  localparam int HTOTAL = HDISP + HFP + HPULSE + HBP;
  localparam int VTOTAL = VDISP + VFP + VPULSE + VBP;

  localparam logic [10:0] H_ACT_END    = 11'(HDISP);
  localparam logic [10:0] H_SYNC_START = 11'(HDISP + HFP);
  localparam logic [10:0] H_SYNC_END   = 11'(HDISP + HFP + HPULSE);
  localparam logic [10:0] H_LAST       = 11'(HTOTAL - 1);
  localparam logic [10:0] V_ACT_END    = 11'(VDISP);
  localparam logic [10:0] V_SYNC_START = 11'(VDISP + VFP);
  localparam logic [10:0] V_SYNC_END   = 11'(VDISP + VFP + VPULSE);
  localparam logic [10:0] V_LAST       = 11'(VTOTAL - 1);

  logic [10:0]      hcnt_reg, hcnt_next;
  logic [10:0]      vcnt_reg, vcnt_next;
  logic             hs_reg, hs_next;
  logic             vs_reg, vs_next;
  logic             blank_reg, blank_next;
  logic [RGB_W-1:0] rgb_reg, rgb_next;
  logic [10:0]      x_reg, x_next;
  logic [10:0]      y_reg, y_next;
  logic             fs_reg, fs_next;
  logic             uf_reg, uf_next;

  logic h_act, v_act, act;
  logic h_sync, v_sync;

  assign h_act  = hcnt_reg < H_ACT_END;
  assign v_act  = vcnt_reg < V_ACT_END;
  assign act    = h_act && v_act;
  assign h_sync = (hcnt_reg >= H_SYNC_START) && (hcnt_reg < H_SYNC_END);
  assign v_sync = (vcnt_reg >= V_SYNC_START) && (vcnt_reg < V_SYNC_END);

  // The counters sit at (0,0) during reset, which decodes as active, so the
  // pop strobe is held off explicitly while reset is asserted.
  assign fifo_rd = act && en && !fifo_empty && !pixel_rst;

  always_comb begin
    hcnt_next = 11'd0;
    vcnt_next = 11'd0;
    if (en) begin
      if (hcnt_reg == H_LAST) begin
        hcnt_next = 11'd0;
        vcnt_next = (vcnt_reg == V_LAST) ? 11'd0 : vcnt_reg + 11'd1;
      end else begin
        hcnt_next = hcnt_reg + 11'd1;
        vcnt_next = vcnt_reg;
      end
    end
  end

  always_comb begin
    hs_next    = 1'b1;
    vs_next    = 1'b1;
    blank_next = 1'b0;
    rgb_next   = '0;
    x_next     = 11'd0;
    y_next     = 11'd0;
    fs_next    = 1'b0;
    uf_next    = uf_reg;
    if (en) begin
      hs_next    = !h_sync;
      vs_next    = !v_sync;
      blank_next = act;
      fs_next    = (hcnt_reg == 11'd0) && (vcnt_reg == 11'd0);
      if (act) begin
        x_next = hcnt_reg;
        y_next = vcnt_reg;
        if (fifo_empty) begin
          uf_next = 1'b1;
        end else begin
          rgb_next = fifo_rdata;
        end
      end
    end
  end

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      hcnt_reg  <= 11'd0;
      vcnt_reg  <= 11'd0;
      hs_reg    <= 1'b1;
      vs_reg    <= 1'b1;
      blank_reg <= 1'b0;
      rgb_reg   <= '0;
      x_reg     <= 11'd0;
      y_reg     <= 11'd0;
      fs_reg    <= 1'b0;
      uf_reg    <= 1'b0;
    end else begin
      hcnt_reg  <= hcnt_next;
      vcnt_reg  <= vcnt_next;
      hs_reg    <= hs_next;
      vs_reg    <= vs_next;
      blank_reg <= blank_next;
      rgb_reg   <= rgb_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      fs_reg    <= fs_next;
      uf_reg    <= uf_next;
    end
  end

  assign VGA_HS      = hs_reg;
  assign VGA_VS      = vs_reg;
  assign VGA_BLANK   = blank_reg;
  assign VGA_RGB     = rgb_reg;
  assign pixel_x     = x_reg;
  assign pixel_y     = y_reg;
  assign frame_start = fs_reg;
  assign underflow   = uf_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen with a tiny 8x6 raster; scoreboard of expected
// registered outputs plus a table of fixed raster positions.
module tb_vga_timing_gen;

  logic        clk;
  logic        rst;
  logic        en;
  logic [23:0] fifo_rdata;
  logic        fifo_empty;
  logic        fifo_rd;
  logic        hs, vs, blank;
  logic [23:0] rgb;
  logic [10:0] px, py;
  logic        fs, uf;

  vga_timing_gen #(
    .HDISP(4), .HFP(1), .HPULSE(2), .HBP(1),
    .VDISP(3), .VFP(1), .VPULSE(1), .VBP(1),
    .RGB_W(24)
  ) dut (
    .pixel_clk(clk), .pixel_rst(rst), .en(en),
    .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
    .VGA_HS(hs), .VGA_VS(vs), .VGA_BLANK(blank), .VGA_RGB(rgb),
    .pixel_x(px), .pixel_y(py), .frame_start(fs), .underflow(uf)
  );

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        blank;
    logic [23:0] rgb;
    logic [10:0] x;
    logic [10:0] y;
    logic        fs;
    logic        uf;
  } out_t;

  typedef struct {
    int   h;
    int   v;
    logic hs;
    logic vs;
    logic blank;
    logic fs;
  } vec_t;

  out_t        sb[$];
  out_t        last;
  logic        last_rd;
  int          checks = 0;
  int          errors = 0;
  int          m_h, m_v;
  logic        m_uf;
  logic [23:0] data_ctr;
  int          ncyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, required finish before 100000");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, a, e, $time);
    end
  endtask

  // Entered and left at posedge+1; one raster cycle per call.
  task automatic step();
    out_t e;
    out_t a;
    logic act_m, rd_m, on;
    fifo_rdata = data_ctr;
    #1;
    act_m = (m_h < 4) && (m_v < 3);
    on    = en && act_m;
    rd_m  = on && !fifo_empty;
    chk("fifo_rd", fifo_rd, rd_m);
    last_rd = fifo_rd;
    e.hs    = !(en && m_h >= 5 && m_h < 7);
    e.vs    = !(en && m_v == 4);
    e.blank = on;
    e.rgb   = (on && !fifo_empty) ? data_ctr : 24'd0;
    e.x     = on ? 11'(m_h) : 11'd0;
    e.y     = on ? 11'(m_v) : 11'd0;
    e.fs    = en && m_h == 0 && m_v == 0;
    m_uf    = m_uf | (on && fifo_empty);
    e.uf    = m_uf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    a = {hs, vs, blank, rgb, px, py, fs, uf};
    e = sb.pop_front();
    chk("outputs", a, e);
    last = a;
    $display("cyc %0d h=%0d v=%0d en=%0b emp=%0b rd=%0b hs=%0b vs=%0b blank=%0b rgb=%0h x=%0d y=%0d fs=%0b uf=%0b",
             ncyc, m_h, m_v, en, fifo_empty, last_rd, a.hs, a.vs, a.blank, a.rgb, a.x, a.y, a.fs, a.uf);
    ncyc++;
    if (rd_m) data_ctr++;
    if (!en) begin
      m_h = 0;
      m_v = 0;
    end else if (m_h == 7) begin
      m_h = 0;
      m_v = (m_v == 5) ? 0 : m_v + 1;
    end else begin
      m_h++;
    end
  endtask

  task automatic goto_pos(input int h, input int v);
    int n = 0;
    while (!(m_h == h && m_v == v) && n < 200) begin
      step();
      n++;
    end
    chk("goto_reached", (m_h == h && m_v == v), 1'b1);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, {hs, vs, blank, rgb, px, py, fs, uf}, {1'b1, 1'b1, 1'b0, 24'd0, 11'd0, 11'd0, 1'b0, 1'b0});
    chk({name, "_rd"}, fifo_rd, 1'b0);
  endtask

  initial begin
    vec_t tbl[10];
    int   rd_cnt, hs_low, vs_low, fs_cnt;
    int   fs_idx[$];
    logic [23:0] rgbq[$];

    tbl[0] = '{0, 0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[1] = '{3, 0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{4, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{5, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{6, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{7, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{0, 3, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{2, 4, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{5, 4, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{0, 5, 1'b1, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; en = 1'b1; fifo_empty = 1'b0;
    data_ctr = 24'd0; fifo_rdata = 24'd0;
    m_h = 0; m_v = 0; m_uf = 1'b0;
    #12;
    chk_reset_outputs("reset_state");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Two full frames from reset: pop count, sync widths, frame_start period, pixel data order.
    rd_cnt = 0; hs_low = 0; vs_low = 0; fs_cnt = 0;
    for (int i = 0; i < 96; i++) begin
      step();
      if (i < 48) begin
        if (last_rd) rd_cnt++;
        if (!last.hs) hs_low++;
        if (!last.vs) vs_low++;
        if (last.blank) rgbq.push_back(last.rgb);
      end
      if (last.fs) fs_idx.push_back(i);
    end
    chk("rd_per_frame", rd_cnt, 12);
    chk("hs_low_cycles", hs_low, 12);
    chk("vs_low_cycles", vs_low, 8);
    chk("fs_count", fs_idx.size(), 2);
    if (fs_idx.size() == 2) begin
      chk("fs_first", fs_idx[0], 0);
      chk("fs_period", fs_idx[1] - fs_idx[0], 48);
    end
    chk("rgb_count", rgbq.size(), 12);
    for (int i = 0; i < rgbq.size(); i++) chk($sformatf("rgb_seq%0d", i), rgbq[i], i);
    chk("no_underflow", uf, 1'b0);

    // Raster positions with fixed expected sync/blank/frame_start.
    for (int i = 0; i < 10; i++) begin
      goto_pos(tbl[i].h, tbl[i].v);
      step();
      chk($sformatf("tbl%0d_h%0d_v%0d", i, tbl[i].h, tbl[i].v),
          {last.hs, last.vs, last.blank, last.fs},
          {tbl[i].hs, tbl[i].vs, tbl[i].blank, tbl[i].fs});
    end

    // Starved FIFO on line 1 pixel 2.
    goto_pos(2, 1);
    fifo_empty = 1'b1;
    step();
    fifo_empty = 1'b0;
    chk("uflow_rd", last_rd, 1'b0);
    chk("uflow_rgb", last.rgb, 24'd0);
    chk("uflow_set", last.uf, 1'b1);
    for (int i = 0; i < 20; i++) step();
    chk("uflow_sticky", uf, 1'b1);

    // Enable gap mid-line.
    goto_pos(2, 1);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("gap_rd%0d", i), last_rd, 1'b0);
      chk($sformatf("gap_out%0d", i), last, {1'b1, 1'b1, 1'b0, 24'd0, 11'd0, 11'd0, 1'b0, 1'b1});
    end
    en = 1'b1;
    step();
    chk("reenable_fs", last.fs, 1'b1);
    chk("reenable_uf_held", last.uf, 1'b1);

    // Asynchronous reset in the middle of an active pixel.
    goto_pos(1, 1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_h = 0; m_v = 0; m_uf = 1'b0;
    step();
    chk("post_reset_fs", last.fs, 1'b1);
    chk("post_reset_uf", last.uf, 1'b0);
    for (int i = 0; i < 10; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
